// File: rtl/ghost_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_spawn_scheduler
//  Purpose  : Sequences up to NUM_GHOSTS ghost slots through
//             IDLE -> ACTIVE -> DYING -> COOLDOWN -> IDLE. It issues spawn
//             strobes with a start X position and counts kills for scoring.
//  Ports    : clk, reset (sync, active-high), startOfFrame (frame tick),
//             game_enable (run/freeze), collision[N] (per-slot hit)
//             -> ghost_active[N], ghost_dying[N], spawn_pulse[N],
//                spawn_x[11], kill_count[16], all_idle
//  Options  : GHOST_RANDOM_SPAWN_EN - when defined, spawn_x is taken from a
//             16-bit Galois LFSR reduced mod (SCREEN_W-63). When undefined,
//             each slot spawns at its own fixed, evenly spaced position.
//  Revision : 1.0 - initial release
// ============================================================================
module ghost_spawn_scheduler #(
    parameter int NUM_GHOSTS      = 4,
    parameter int SPAWN_INTERVAL  = 90,
    parameter int DYING_FRAMES    = 16,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int SCREEN_W        = 640
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  game_enable,
    input  logic [NUM_GHOSTS-1:0] collision,
    output logic [NUM_GHOSTS-1:0] ghost_active,
    output logic [NUM_GHOSTS-1:0] ghost_dying,
    output logic [NUM_GHOSTS-1:0] spawn_pulse,
    output logic [10:0]           spawn_x,
    output logic [15:0]           kill_count,
    output logic                  all_idle
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_DYING    = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    localparam logic [9:0] c_SPAWN_LOAD = 10'(SPAWN_INTERVAL);
    localparam logic [9:0] c_DYING_LOAD = 10'(DYING_FRAMES);
    localparam logic [9:0] c_COOL_LOAD  = 10'(COOLDOWN_FRAMES);

    logic [NUM_GHOSTS-1:0][1:0] r_state;
    logic [NUM_GHOSTS-1:0][1:0] w_state_nxt;
    logic [NUM_GHOSTS-1:0][9:0] r_cnt;
    logic [NUM_GHOSTS-1:0][9:0] w_cnt_nxt;
    logic [9:0]                 r_spawn_timer;
    logic [9:0]                 w_timer_dec;
    logic [9:0]                 w_timer_nxt;
    logic [NUM_GHOSTS-1:0]      r_spawn_pulse;
    logic [NUM_GHOSTS-1:0]      w_grant;
    logic [NUM_GHOSTS-1:0]      w_idle;
    logic [NUM_GHOSTS-1:0]      w_kill;
    logic [10:0]                r_spawn_x;
    logic [10:0]                w_spawn_x;
    logic [15:0]                r_kill_count;
    logic [15:0]                w_kill_nxt;
    logic [16:0]                w_kill_sum;
    logic [3:0]                 w_kill_pop;
    logic [2:0]                 w_grant_idx;
    logic                       w_tick;
    logic                       w_attempt;
    logic                       w_any_idle;

    // Frame-rate time only advances while the game is running.
    assign w_tick = startOfFrame & game_enable;

    // Spawn timer: an attempt fires on the tick that brings it to zero, and
    // keeps firing on every later tick while it is parked at zero.
    always_comb begin
        w_timer_dec = (r_spawn_timer == 10'd0) ? 10'd0 : r_spawn_timer - 10'd1;
        w_attempt   = w_tick && (w_timer_dec == 10'd0);
        w_timer_nxt = r_spawn_timer;
        if (w_tick) begin
            w_timer_nxt = (w_attempt && w_any_idle) ? c_SPAWN_LOAD : w_timer_dec;
        end
    end

    // Lowest-index IDLE slot wins; eligibility uses the registered state, so a
    // slot that returns to IDLE this cycle waits for the next frame tick.
    always_comb begin
        w_grant_idx = 3'd0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            w_idle[i] = (r_state[i] == S_IDLE);
        end
        w_any_idle = |w_idle;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (w_idle[i]) w_grant_idx = 3'(i);
        end
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            w_grant[i] = w_attempt && w_any_idle && (w_grant_idx == 3'(i));
        end
    end

`ifdef GHOST_RANDOM_SPAWN_EN
    localparam logic [10:0] c_MOD  = 11'(SCREEN_W - 63);
    localparam int          c_NSUB = 2047 / (SCREEN_W - 63);

    logic [15:0] r_lfsr;
    logic [10:0] w_rand_x;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, free-running every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Modulo by a constant, unrolled into a fixed chain of compare/subtract.
    always_comb begin
        w_rand_x = r_lfsr[10:0];
        for (int k = 0; k < c_NSUB; k++) begin
            if (w_rand_x >= c_MOD) w_rand_x = w_rand_x - c_MOD;
        end
    end

    assign w_spawn_x = w_rand_x;
`else
    localparam int          c_DIV    = (NUM_GHOSTS > 1) ? NUM_GHOSTS - 1 : 1;
    localparam int          c_STEP   = (NUM_GHOSTS > 1) ? (SCREEN_W - 64) / c_DIV : 0;
    localparam logic [10:0] c_STEP_X = 11'(c_STEP);

    assign w_spawn_x = c_STEP_X * {8'd0, w_grant_idx};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= '0;
            r_cnt         <= '0;
            r_spawn_timer <= c_SPAWN_LOAD;
            r_spawn_pulse <= '0;
            r_spawn_x     <= 11'd0;
            r_kill_count  <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_spawn_timer <= w_timer_nxt;
            r_spawn_pulse <= w_grant;
            if (|w_grant) r_spawn_x <= w_spawn_x;
            r_kill_count  <= w_kill_nxt;
        end
    end

    // Next-state logic for every slot; the whole array freezes while disabled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kill      = '0;
        if (game_enable) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_grant[i]) w_state_nxt[i] = S_ACTIVE;
                    end
                    S_ACTIVE: begin
                        if (collision[i]) begin
                            w_state_nxt[i] = S_DYING;
                            w_cnt_nxt[i]   = c_DYING_LOAD;
                            w_kill[i]      = 1'b1;
                        end
                    end
                    S_DYING: begin
                        if (startOfFrame) begin
                            if (r_cnt[i] <= 10'd1) begin
                                w_state_nxt[i] = S_COOLDOWN;
                                w_cnt_nxt[i]   = c_COOL_LOAD;
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] - 10'd1;
                            end
                        end
                    end
                    default: begin
                        if (startOfFrame) begin
                            if (r_cnt[i] <= 10'd1) begin
                                w_state_nxt[i] = S_IDLE;
                                w_cnt_nxt[i]   = 10'd0;
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] - 10'd1;
                            end
                        end
                    end
                endcase
            end
        end

        // Simultaneous kills all count; the total pins at all-ones.
        w_kill_pop = 4'd0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            w_kill_pop = w_kill_pop + 4'(w_kill[i]);
        end
        w_kill_sum = {1'b0, r_kill_count} + {13'd0, w_kill_pop};
        w_kill_nxt = w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
    end

    // Output decode straight from registered state
    always_comb begin
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            ghost_active[i] = (r_state[i] == S_ACTIVE);
            ghost_dying[i]  = (r_state[i] == S_DYING);
        end
        all_idle    = &w_idle;
        spawn_pulse = r_spawn_pulse;
        spawn_x     = r_spawn_x;
        kill_count  = r_kill_count;
    end

endmodule
`default_nettype wire
